mem_stage: RTL

Memory-access stage of the five-stage MIPS/DLX pipeline, sitting between the EX/MEM latch and the MEM_WB latch. Performs loads and stores of byte, halfword and word size against a data-memory port with a req/ack handshake. Formats load data (lane select, sign/zero extend) and stalls upstream while an access is outstanding. Presents registered write-back data, ALU result, destination register and WB control to MEM_WB.

---
 rtl/mem_stage.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage between EX/MEM and MEM_WB: byte/half/word loads and stores
// over a req/ack data-memory port, with load formatting, upstream stall and ack timeout.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        enable,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  input  logic [1:0]  WB_control_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rw_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [1:0]  WB_control_out,
  output logic [31:0] data_from_mem_out,
  output logic [31:0] data_from_ALU_out,
  output logic [4:0]  rw_out,
  output logic        valid_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  // Memory handshake: dmem_req rises on the edge after an aligned access is
  // accepted and stays high, with all bus fields frozen, until the edge after
  // the cycle in which dmem_ack is seen (or the timeout cycle).

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [31:0]       cap_alu_q,   cap_alu_d;
  logic [1:0]        cap_size_q,  cap_size_d;
  logic              cap_uns_q,   cap_uns_d;
  logic [1:0]        cap_wb_q,    cap_wb_d;
  logic [4:0]        cap_rw_q,    cap_rw_d;
  logic              req_q,       req_d;
  logic              we_q,        we_d;
  logic [31:0]       addr_q,      addr_d;
  logic [3:0]        be_q,        be_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [1:0]        wb_out_q,    wb_out_d;
  logic [31:0]       mem_out_q,   mem_out_d;
  logic [31:0]       alu_out_q,   alu_out_d;
  logic [4:0]        rw_out_q,    rw_out_d;
  logic              valid_q,     valid_d;
  logic              mis_q,       mis_d;
  logic              berr_q,      berr_d;

  logic              stall_c;
  logic              access;
  logic              misaligned;
  logic [1:0]        size_in;

  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b1000 >> lo;
      SZ_HALF: be = lo[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Big-endian lane pick: byte offset 0 lives in the most significant lane.
  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[31:24];
      2'd1:    b = rd[23:16];
      2'd2:    b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = lo[1] ? rd[15:0] : rd[31:16];
    case (sz)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_comb begin
    size_in    = norm_size(mem_size_in);
    access     = valid_in & (mem_read_in | mem_write_in);
    misaligned = ((size_in == SZ_HALF) & alu_result_in[0]) |
                 ((size_in == SZ_WORD) & (|alu_result_in[1:0]));

    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_alu_d  = cap_alu_q;
    cap_size_d = cap_size_q;
    cap_uns_d  = cap_uns_q;
    cap_wb_d   = cap_wb_q;
    cap_rw_d   = cap_rw_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_out_d   = wb_out_q;
    mem_out_d  = mem_out_q;
    alu_out_d  = alu_out_q;
    rw_out_d   = rw_out_q;
    valid_d    = 1'b0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    stall_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_d = 1'b0;
        if (access && !misaligned) begin
          stall_c    = 1'b1;
          state_d    = S_WAIT;
          cnt_d      = '0;
          cap_alu_d  = alu_result_in;
          cap_size_d = size_in;
          cap_uns_d  = mem_unsigned_in;
          cap_wb_d   = WB_control_in;
          cap_rw_d   = rw_in;
          req_d      = 1'b1;
          we_d       = mem_write_in;
          addr_d     = {alu_result_in[31:2], 2'b00};
          be_d       = lane_be(size_in, alu_result_in[1:0]);
          wdata_d    = lane_wdata(size_in, store_data_in);
        end else begin
          // Non-access pass-through; a misaligned access retires with writeback killed.
          wb_out_d  = (access && misaligned) ? 2'b00 : WB_control_in;
          alu_out_d = alu_result_in;
          rw_out_d  = rw_in;
          mem_out_d = '0;
          valid_d   = valid_in;
          mis_d     = access && misaligned;
        end
      end
      S_WAIT: begin
        stall_c = ~(dmem_ack | (cnt_q == CNT_LAST));
        if (dmem_ack) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          wb_out_d  = cap_wb_q;
          alu_out_d = cap_alu_q;
          rw_out_d  = cap_rw_q;
          mem_out_d = we_q ? 32'h0 : fmt_load(dmem_rdata, cap_size_q, cap_alu_q[1:0], cap_uns_q);
          valid_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          req_d     = 1'b0;
          wb_out_d  = 2'b00;
          alu_out_d = cap_alu_q;
          rw_out_d  = cap_rw_q;
          mem_out_d = '0;
          valid_d   = 1'b1;
          berr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge enable) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_alu_q  <= '0;
      cap_size_q <= '0;
      cap_uns_q  <= 1'b0;
      cap_wb_q   <= '0;
      cap_rw_q   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_out_q   <= '0;
      mem_out_q  <= '0;
      alu_out_q  <= '0;
      rw_out_q   <= '0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_alu_q  <= cap_alu_d;
      cap_size_q <= cap_size_d;
      cap_uns_q  <= cap_uns_d;
      cap_wb_q   <= cap_wb_d;
      cap_rw_q   <= cap_rw_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_out_q   <= wb_out_d;
      mem_out_q  <= mem_out_d;
      alu_out_q  <= alu_out_d;
      rw_out_q   <= rw_out_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign stall_out         = stall_c & ~reset;
  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_be           = be_q;
  assign dmem_wdata        = wdata_q;
  assign WB_control_out    = wb_out_q;
  assign data_from_mem_out = mem_out_q;
  assign data_from_ALU_out = alu_out_q;
  assign rw_out            = rw_out_q;
  assign valid_out         = valid_q;
  assign misaligned_out    = mis_q;
  assign bus_error_out     = berr_q;

endmodule
